// File: rtl/npc_pc_unit_if.sv
// ----------------------------------------------------------------------------
// npc_pc_unit_if
// Bundle between the decode/hazard side (master) and the next-PC unit (slave).
//   Master drives : stall, D_PC, D_Imm26, br_type, br_likely, jump, jr,
//                   jr_target, comparator flags (Zero..LIS)
//   Slave drives  : F_PC, npc, taken, clr_slot, link_addr, br_cnt, taken_cnt
// ----------------------------------------------------------------------------
interface npc_pc_unit_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             stall;
    logic [31:0]      D_PC;
    logic [25:0]      D_Imm26;
    logic [3:0]       br_type;
    logic             br_likely;
    logic             jump;
    logic             jr;
    logic [31:0]      jr_target;
    logic             Zero;
    logic             GZ;
    logic             LZ;
    logic             GS;
    logic             LS;
    logic             GU;
    logic             LU;
    logic             GIS;
    logic             LIS;

    logic [31:0]      F_PC;
    logic [31:0]      npc;
    logic             taken;
    logic             clr_slot;
    logic [31:0]      link_addr;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, D_PC, D_Imm26, br_type, br_likely, jump, jr, jr_target,
        output Zero, GZ, LZ, GS, LS, GU, LU, GIS, LIS,
        input  F_PC, npc, taken, clr_slot, link_addr, br_cnt, taken_cnt
    );

    modport slave (
        input  stall, D_PC, D_Imm26, br_type, br_likely, jump, jr, jr_target,
        input  Zero, GZ, LZ, GS, LS, GU, LU, GIS, LIS,
        output F_PC, npc, taken, clr_slot, link_addr, br_cnt, taken_cnt
    );
endinterface

// File: rtl/npc_pc_unit.sv
// ----------------------------------------------------------------------------
// npc_pc_unit
// Next-PC stage: resolves the branch/jump of the instruction in D, holds the
// fetch PC, produces the link address and the branch-likely slot clear, and
// counts resolved / taken conditional branches.
//   clk    : system clock, all state on rising edge
//   reset  : synchronous active-high reset (overrides stall)
//   bus    : npc_pc_unit_if.slave (D-stage controls, flags, PC/counter outputs)
// ----------------------------------------------------------------------------
module npc_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    npc_pc_unit_if.slave  bus
);

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_GZ   = 4'd3,
        BR_NGZ  = 4'd4,
        BR_LZ   = 4'd5,
        BR_NLZ  = 4'd6,
        BR_GS   = 4'd7,
        BR_LS   = 4'd8,
        BR_GU   = 4'd9,
        BR_LU   = 4'd10,
        BR_GIS  = 4'd11,
        BR_LIS  = 4'd12
    } br_type_e;

    logic [31:0]      r_f_pc;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic             w_cond;
    logic             w_br_valid;
    logic             w_br_taken;
    logic             w_uncond;
    logic [15:0]      w_imm16;
    logic [31:0]      w_dpc_plus4;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_tgt;
    logic [31:0]      w_j_tgt;
    logic [31:0]      w_npc;

    // Condition decode; reserved codes (13-15) stay invalid and never taken.
    always_comb begin
        w_cond     = 1'b0;
        w_br_valid = 1'b1;
        case (bus.br_type)
            BR_EQ:   w_cond = bus.Zero;
            BR_NE:   w_cond = ~bus.Zero;
            BR_GZ:   w_cond = bus.GZ;
            BR_NGZ:  w_cond = ~bus.GZ;
            BR_LZ:   w_cond = bus.LZ;
            BR_NLZ:  w_cond = ~bus.LZ;
            BR_GS:   w_cond = bus.GS;
            BR_LS:   w_cond = bus.LS;
            BR_GU:   w_cond = bus.GU;
            BR_LU:   w_cond = bus.LU;
            BR_GIS:  w_cond = bus.GIS;
            BR_LIS:  w_cond = bus.LIS;
            default: w_br_valid = 1'b0;
        endcase
    end

    assign w_imm16     = bus.D_Imm26[15:0];
    assign w_dpc_plus4 = bus.D_PC + 32'd4;
    assign w_pc_plus4  = r_f_pc + 32'd4;
    assign w_br_tgt    = w_dpc_plus4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign w_j_tgt     = {w_dpc_plus4[31:28], bus.D_Imm26, 2'b00};

    assign w_br_taken  = w_br_valid & w_cond;
    assign w_uncond    = bus.jr | bus.jump;

    // jr > jump > conditional branch > sequential
    always_comb begin
        w_npc = w_pc_plus4;
        if (bus.jr)
            w_npc = bus.jr_target;
        else if (bus.jump)
            w_npc = w_j_tgt;
        else if (w_br_taken)
            w_npc = w_br_tgt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc      <= PC_RESET;
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (!bus.stall) begin
            r_f_pc <= w_npc;
            // jr/jump mask br_type, so a stray code there is not counted
            if (!w_uncond) begin
                r_br_cnt    <= r_br_cnt    + CNT_W'(w_br_valid);
                r_taken_cnt <= r_taken_cnt + CNT_W'(w_br_taken);
            end
        end
    end

    assign bus.F_PC      = r_f_pc;
    assign bus.npc       = w_npc;
    assign bus.taken     = w_uncond | w_br_taken;
    assign bus.clr_slot  = bus.br_likely & w_br_valid & ~w_cond & ~w_uncond & ~bus.stall;
    assign bus.link_addr = bus.D_PC + 32'd8;
    assign bus.br_cnt    = r_br_cnt;
    assign bus.taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_npc_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_npc_pc_unit
// Bench for npc_pc_unit: a 32-bit-counter instance driven from a vector table
// with post-edge expectations queued, a condition-decode sweep, and a 4-bit
// counter instance for the counter wrap.
// ----------------------------------------------------------------------------
module tb_npc_pc_unit;

    localparam logic [8:0] F_ZERO = 9'h100;
    localparam logic [8:0] F_GZ   = 9'h080;
    localparam logic [8:0] F_LS   = 9'h010;

    logic clk;
    logic reset;

    npc_pc_unit_if #(.CNT_W(32)) b  ();
    npc_pc_unit_if #(.CNT_W(4))  b4 ();

    npc_pc_unit #(.PC_RESET(32'h0000_3000), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    npc_pc_unit #(.PC_RESET(32'h0000_0100), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [31:0] d_pc;
        logic [25:0] imm;
        logic [3:0]  bt;
        logic        likely;
        logic        jump;
        logic        jr;
        logic [31:0] jr_tgt;
        logic [8:0]  flags;
        logic        chk_comb;
        logic [31:0] e_npc;
        logic        e_taken;
        logic        e_clr;
        logic [31:0] e_fpc;
        logic [31:0] e_br;
        logic [31:0] e_tk;
    } vec_t;

    typedef struct {
        logic [31:0] fpc;
        logic [31:0] br;
        logic [31:0] tk;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic rst, input logic stall, input logic [31:0] d_pc,
        input logic [25:0] imm, input logic [3:0] bt, input logic likely,
        input logic jump, input logic jr, input logic [31:0] jr_tgt,
        input logic [8:0] flags, input logic chk_comb, input logic [31:0] e_npc,
        input logic e_taken, input logic e_clr, input logic [31:0] e_fpc,
        input logic [31:0] e_br, input logic [31:0] e_tk);
        vec_t r;
        r.rst = rst; r.stall = stall; r.d_pc = d_pc; r.imm = imm; r.bt = bt;
        r.likely = likely; r.jump = jump; r.jr = jr; r.jr_tgt = jr_tgt;
        r.flags = flags; r.chk_comb = chk_comb; r.e_npc = e_npc;
        r.e_taken = e_taken; r.e_clr = e_clr; r.e_fpc = e_fpc;
        r.e_br = e_br; r.e_tk = e_tk;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        reset       = x.rst;
        b.stall     = x.stall;
        b.D_PC      = x.d_pc;
        b.D_Imm26   = x.imm;
        b.br_type   = x.bt;
        b.br_likely = x.likely;
        b.jump      = x.jump;
        b.jr        = x.jr;
        b.jr_target = x.jr_tgt;
        {b.Zero, b.GZ, b.LZ, b.GS, b.LS, b.GU, b.LU, b.GIS, b.LIS} = x.flags;
    endtask

    task automatic apply(input vec_t x, input int idx);
        exp_t e;
        @(negedge clk);
        drive(x);
        #1;
        if (x.chk_comb) begin
            chk($sformatf("v%0d npc", idx),   b.npc,   x.e_npc);
            chk($sformatf("v%0d taken", idx), {31'b0, b.taken},    {31'b0, x.e_taken});
            chk($sformatf("v%0d clr_slot", idx), {31'b0, b.clr_slot}, {31'b0, x.e_clr});
            chk($sformatf("v%0d link", idx),  b.link_addr, x.d_pc + 32'd8);
        end
        sbq.push_back('{fpc: x.e_fpc, br: x.e_br, tk: x.e_tk});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk($sformatf("v%0d F_PC", idx),      b.F_PC,      e.fpc);
        chk($sformatf("v%0d br_cnt", idx),    b.br_cnt,    e.br);
        chk($sformatf("v%0d taken_cnt", idx), b.taken_cnt, e.tk);
    endtask

    // flag bit (8=Zero .. 0=LIS) and inversion for each br_type 1..12
    int unsigned sel_bit [13] = '{0, 8, 8, 7, 7, 6, 6, 5, 4, 3, 2, 1, 0};
    logic        sel_neg [13] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t        e;
        logic [3:0]  c4;
        logic        exp_tk;
        logic [8:0]  fl;

        reset = 1'b1;
        drive(mk(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        b4.stall = 1'b1; b4.D_PC = '0; b4.D_Imm26 = '0; b4.br_type = '0;
        b4.br_likely = 1'b0; b4.jump = 1'b0; b4.jr = 1'b0; b4.jr_target = '0;
        {b4.Zero, b4.GZ, b4.LZ, b4.GS, b4.LS, b4.GU, b4.LU, b4.GIS, b4.LIS} = '0;

        //                rst st d_pc           imm26         bt  lk jp jr jr_tgt         flags    ck npc            tk cl fpc            br tk
        vecs.push_back(mk(1, 1, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   0, 32'h0,         0, 0, 32'h3000,     0, 0));
        vecs.push_back(mk(1, 1, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   1, 32'h3004,      0, 0, 32'h3000,     0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   1, 32'h3004,      0, 0, 32'h3004,     0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   1, 32'h3008,      0, 0, 32'h3008,     0, 0));
        vecs.push_back(mk(0, 0, 32'h3004,      26'h0003,     1,  0, 0, 0, 32'h0,         F_ZERO, 1, 32'h3014,      1, 0, 32'h3014,     1, 1));
        vecs.push_back(mk(0, 0, 32'h3010,      26'hFFFE,     8,  0, 0, 0, 32'h0,         F_LS,   1, 32'h300C,      1, 0, 32'h300C,     2, 2));
        vecs.push_back(mk(0, 0, 32'h3010,      26'h0,        2,  1, 0, 0, 32'h0,         F_ZERO, 1, 32'h3010,      0, 1, 32'h3010,     3, 2));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 32'h3010,  26'h0010,     3,  0, 0, 0, 32'h0,         F_GZ,   1, 32'h3054,      1, 0, 32'h3010,     3, 2));
        vecs.push_back(mk(0, 0, 32'h3010,      26'h0010,     3,  0, 0, 0, 32'h0,         F_GZ,   1, 32'h3054,      1, 0, 32'h3054,     4, 3));
        vecs.push_back(mk(0, 0, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   1, 32'h3058,      0, 0, 32'h3058,     4, 3));
        vecs.push_back(mk(0, 0, 32'h3054,      26'h0,        1,  0, 1, 1, 32'h4000,      F_ZERO, 1, 32'h4000,      1, 0, 32'h4000,     4, 3));
        vecs.push_back(mk(0, 0, 32'h3000,      26'h0000C10,  0,  0, 1, 0, 32'h0,         9'h0,   1, 32'h3040,      1, 0, 32'h3040,     4, 3));
        vecs.push_back(mk(0, 1, 32'h3040,      26'h0,        1,  1, 0, 0, 32'h0,         9'h0,   1, 32'h3044,      0, 0, 32'h3040,     4, 3));
        vecs.push_back(mk(0, 0, 32'h3040,      26'h0,        13, 1, 0, 0, 32'h0,         9'h1FF, 1, 32'h3044,      0, 0, 32'h3044,     4, 3));
        vecs.push_back(mk(0, 0, 32'h3044,      26'h0,        0,  0, 0, 1, 32'hFFFF_FFFC, 9'h0,   1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 4, 3));
        vecs.push_back(mk(0, 0, 32'h0,         26'h0,        0,  0, 0, 0, 32'h0,         9'h0,   1, 32'h0,         0, 0, 32'h0,        4, 3));
        vecs.push_back(mk(0, 0, 32'hFFFF_FFFC, 26'h0001,     1,  0, 0, 0, 32'h0,         F_ZERO, 1, 32'h4,         1, 0, 32'h4,        5, 4));
        vecs.push_back(mk(0, 0, 32'h7FFF_FFFC, 26'h3FF_FFFF, 0,  0, 1, 0, 32'h0,         9'h0,   1, 32'h8FFF_FFFC, 1, 0, 32'h8FFF_FFFC, 5, 4));
        vecs.push_back(mk(1, 1, 32'h100,       26'h0,        1,  0, 0, 0, 32'h0,         F_ZERO, 1, 32'h104,       1, 0, 32'h3000,     0, 0));

        foreach (vecs[i]) apply(vecs[i], i);

        // Condition decode sweep under stall: nothing may commit.
        @(negedge clk);
        reset = 1'b0;
        drive(mk(0, 1, 32'h2000, 26'h0010, 0, 0, 0, 0, 32'h0, 9'h0, 0, 0, 0, 0, 0, 0, 0));
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 10; k++) begin
                fl = (k < 9) ? (9'h1 << k) : 9'h0;
                b.br_type = 4'(t);
                {b.Zero, b.GZ, b.LZ, b.GS, b.LS, b.GU, b.LU, b.GIS, b.LIS} = fl;
                #1;
                if (t >= 1 && t <= 12)
                    exp_tk = (k == int'(sel_bit[t])) ^ sel_neg[t];
                else
                    exp_tk = 1'b0;
                chk($sformatf("dec t%0d k%0d taken", t, k), {31'b0, b.taken}, {31'b0, exp_tk});
                chk($sformatf("dec t%0d k%0d npc", t, k), b.npc,
                    exp_tk ? 32'h2044 : 32'h3004);
            end
        end
        @(posedge clk); #1;
        chk("dec F_PC held", b.F_PC, 32'h3000);
        chk("dec br_cnt held", b.br_cnt, 32'h0);

        // 4-bit counters: fifteen taken branches saturate, sixteenth wraps.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("w4 reset F_PC", b4.F_PC, 32'h100);
        chk("w4 reset br_cnt", 32'(b4.br_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        b4.stall = 1'b0;
        b4.br_type = 4'd1;
        b4.Zero = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) b4.Zero = 1'b0;
            c4 = 4'(i);
            sbq.push_back('{fpc: (i == 17) ? 32'h8 : 32'h4,
                            br: 32'(c4),
                            tk: (i == 17) ? 32'h0 : 32'(c4)});
            @(posedge clk); #1;
            e = sbq.pop_front();
            chk($sformatf("w4 i%0d F_PC", i), b4.F_PC, e.fpc);
            chk($sformatf("w4 i%0d br_cnt", i), 32'(b4.br_cnt), e.br);
            chk($sformatf("w4 i%0d taken_cnt", i), 32'(b4.taken_cnt), e.tk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
